mem_dev_router: RTL and testbench
=================================

// Module: mem_dev_router
// PURPOSE
//  Routes memory-stage load/store requests to the CLINT (mtime/mtimecmp) or the data bus by address.
//  - Registers one request at a time; runs the target valid/ready handshake.
//  - Returns right-aligned, size-masked load data plus an error flag as a 1-cycle response pulse.
//  - Sits between the pipeline MEM stage (upstream) and mem_clint / dbus master (downstream).
// PARAMETERS
//  DATA_W     64            data path width
//  ADDR_W     64            address width
//  CLINT_BASE 64'h0200_0000 CLINT window base
//  CLINT_MASK 64'hFFFF_0000 address bits compared against CLINT_BASE
// PORTS
//  clk            in  1      clock
//  rst            in  1      synchronous reset, active-high
//  mdr_valid_i    in  1      upstream request valid
//  mdr_req_i      in  1      `REQ_READ / `REQ_WRITE
//  mdr_addr_i     in  ADDR_W byte address
//  mdr_size_i     in  2      0=B 1=H 2=W 3=D
//  mdr_wdata_i    in  DATA_W store data, right-aligned
//  mdr_ready_o    out 1      request accepted when valid&ready
//  mdr_rsp_o      out 1      response pulse, 1 cycle
//  mdr_rdata_o    out DATA_W load data, right-aligned, zero above size
//  mdr_err_o      out 1      response is an error; qualified by mdr_rsp_o
//  clint_valid_o  out 1      \
//  clint_req_o    out 1       |
//  clint_addr_o   out ADDR_W  | CLINT request, held stable until clint_ready_i
//  clint_size_o   out 2       |
//  clint_wdata_o  out DATA_W /
//  clint_ready_i  in  1      CLINT accept/complete (CLINT drives it constant 1)
//  clint_rdata_i  in  DATA_W CLINT read data, combinational, valid with ready
//  clint_resp_i   in  2      0 = OK
//  dbus_*         same 5 outputs + 3 inputs as clint_*; dbus_wdata_o is lane-aligned
// BEHAVIOUR
//  Reset: state=IDLE; all *_valid_o=0; mdr_rsp_o=0; mdr_err_o=0; mdr_rdata_o=0; mdr_ready_o=1 the cycle after reset.
//  Reset mid-transaction: abandons the request, no response; target valid drops the next cycle.
//  State machine, IDLE / CLINT / DBUS / RESP:
//   IDLE: mdr_ready_o=1. On mdr_valid_i, capture req/addr/size/wdata into registers, then:
//     - misaligned (addr mod 2^size != 0) -> RESP, err=1, no target access
//     - (addr & CLINT_MASK)==CLINT_BASE   -> CLINT
//     - otherwise                          -> DBUS
//   CLINT/DBUS: mdr_ready_o=0.
//     - Target valid=1 with registered fields.
//     - On ready_i: sample rdata_i and resp_i, -> RESP.
//     - While ready_i=0: hold all fields stable, no timeout.
//   RESP: mdr_rsp_o=1 for exactly one cycle; err = (resp!=0) | misaligned; -> IDLE.
//     - mdr_ready_o=0 in RESP; a request valid in RESP waits until IDLE.
//  Latency: accept at T; target valid at T+1; ready at T+1+n; response at T+2+n.
//   CLINT (n=0): response at T+2.
//  Data formatting (off = addr[2:0]):
//   - Load: rdata_o = (rdata_i >> 8*off) & size_mask.
//     size_mask = 0xFF, 0xFFFF, 0xFFFF_FFFF or all-ones for B/H/W/D. No sign extension (MEM stage does it).
//   - Store to dbus: wdata << 8*off. Store to CLINT: wdata unshifted.
//   - Writes return rdata_o=0.
//  mdr_rdata_o / mdr_err_o are registered; they hold until the next response.
// STRUCTURE
//  Constants in defines.v:
//   - REQ_READ/REQ_WRITE, SIZE_B/H/W/D
//   - MDR_IDLE/CLINT/DBUS/RESP state codes (2 bits)
//   - CLINT_BASE/CLINT_MASK defaults
//  Sub-module mem_lane_align (combinational): size mask, load extract, store shift; shared with a later dcache.
//  This module owns only the FSM and capture registers.
// TESTING
//  1. CLINT write 64'h1234 at 0x0200_4000, size D
//     -> clint_valid_o 1 cycle at T+1, wdata 64'h1234 unshifted; mdr_rsp_o at T+2, err=0.
//  2. CLINT read at 0x0200_BFF8 after mtime preloaded to 64'h10
//     -> mdr_rdata_o=64'h10 (+ ticks); rsp at T+2; dbus_valid_o never asserts.
//  3. Dbus byte load at 0x8000_0003, dbus_ready_i low 3 cycles, rdata 64'hAABBCCDD_11223344
//     -> fields stable throughout; rdata_o=64'h11; rsp at T+5.
//  4. Halfword store at 0x8000_0001 (misaligned)
//     -> no target valid; rsp at T+1 with err=1; ready returns next cycle.
//  5. Dbus resp_i=2'b10 on word read
//     -> err=1; back-to-back valid held high -> second request accepted the cycle after rsp.
//  6. Assert rst during DBUS wait -> no mdr_rsp_o; dbus_valid_o=0 next cycle; IDLE, ready=1.

Source files
------------

// File: rtl/mem_dev_router_pkg.sv
// Shared types and constants for the memory-stage device router.
// Covers request kinds, access sizes, FSM state codes and CLINT window defaults.
package mem_dev_router_pkg;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [63:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;
    localparam logic [63:0] CLINT_MASK_DEF = 64'hFFFF_FFFF_FFFF_0000;

    typedef enum logic [1:0] {
        MDR_IDLE  = 2'd0,
        MDR_CLINT = 2'd1,
        MDR_DBUS  = 2'd2,
        MDR_RESP  = 2'd3
    } mdr_state_e;

    // An access is misaligned when any offset bit below its natural size is set.
    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: size mask, right-aligned load extract and store lane shift.
// Purely combinational so a later dcache can reuse it unchanged.
module mem_lane_align
    import mem_dev_router_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [2:0]        off,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_out,
    output logic [DATA_W-1:0] store_out
);

    logic [DATA_W-1:0] size_mask;
    logic [5:0]        shamt;

    assign shamt = {off, 3'b000};

    always_comb begin
        // NOTE: default assignment first so every path drives size_mask and no latch is inferred.
        size_mask = '1;
        case (size)
            SIZE_B:  size_mask = DATA_W'(8'hFF);
            SIZE_H:  size_mask = DATA_W'(16'hFFFF);
            SIZE_W:  size_mask = DATA_W'(32'hFFFF_FFFF);
            default: size_mask = '1;
        endcase
    end

    assign load_out  = (load_data >> shamt) & size_mask;
    assign store_out = store_data << shamt;

endmodule

// File: rtl/mem_dev_router.sv
// Routes one MEM-stage load/store at a time to the CLINT or the data bus by address,
// then returns a one-cycle response with aligned load data and an error flag.
module mem_dev_router
    import mem_dev_router_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] CLINT_BASE = ADDR_W'(CLINT_BASE_DEF),
    parameter logic [ADDR_W-1:0] CLINT_MASK = ADDR_W'(CLINT_MASK_DEF)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mdr_valid_i,
    input  logic              mdr_req_i,
    input  logic [ADDR_W-1:0] mdr_addr_i,
    input  logic [1:0]        mdr_size_i,
    input  logic [DATA_W-1:0] mdr_wdata_i,
    output logic              mdr_ready_o,
    output logic              mdr_rsp_o,
    output logic [DATA_W-1:0] mdr_rdata_o,
    output logic              mdr_err_o,

    output logic              clint_valid_o,
    output logic              clint_req_o,
    output logic [ADDR_W-1:0] clint_addr_o,
    output logic [1:0]        clint_size_o,
    output logic [DATA_W-1:0] clint_wdata_o,
    input  logic              clint_ready_i,
    input  logic [DATA_W-1:0] clint_rdata_i,
    input  logic [1:0]        clint_resp_i,

    output logic              dbus_valid_o,
    output logic              dbus_req_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [1:0]        dbus_size_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_ready_i,
    input  logic [DATA_W-1:0] dbus_rdata_i,
    input  logic [1:0]        dbus_resp_i
);

    mdr_state_e        state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] load_src;
    logic [DATA_W-1:0] load_aligned;
    logic [DATA_W-1:0] store_shifted;

    assign load_src = (state == MDR_CLINT) ? clint_rdata_i : dbus_rdata_i;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .off        (addr_q[2:0]),
        .size       (size_q),
        .load_data  (load_src),
        .store_data (wdata_q),
        .load_out   (load_aligned),
        .store_out  (store_shifted)
    );

    // Both targets see the captured fields; only the valid selects which one acts.
    assign clint_req_o   = req_q;
    assign clint_addr_o  = addr_q;
    assign clint_size_o  = size_q;
    assign clint_wdata_o = wdata_q;
    assign dbus_req_o    = req_q;
    assign dbus_addr_o   = addr_q;
    assign dbus_size_o   = size_q;
    assign dbus_wdata_o  = store_shifted;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state         <= MDR_IDLE;
            mdr_ready_o   <= 1'b1;
            mdr_rsp_o     <= 1'b0;
            mdr_err_o     <= 1'b0;
            mdr_rdata_o   <= '0;
            clint_valid_o <= 1'b0;
            dbus_valid_o  <= 1'b0;
            req_q         <= REQ_READ;
            addr_q        <= '0;
            size_q        <= SIZE_B;
            wdata_q       <= '0;
        end else begin
            mdr_rsp_o <= 1'b0;
            case (state)
                MDR_IDLE: begin
                    if (mdr_valid_i) begin
                        req_q       <= mdr_req_i;
                        addr_q      <= mdr_addr_i;
                        size_q      <= mdr_size_i;
                        wdata_q     <= mdr_wdata_i;
                        mdr_ready_o <= 1'b0;
                        if (is_misaligned(mdr_addr_i[2:0], mdr_size_i)) begin
                            state       <= MDR_RESP;
                            mdr_rsp_o   <= 1'b1;
                            mdr_err_o   <= 1'b1;
                            mdr_rdata_o <= '0;
                        end else if ((mdr_addr_i & CLINT_MASK) == CLINT_BASE) begin
                            state         <= MDR_CLINT;
                            clint_valid_o <= 1'b1;
                        end else begin
                            state        <= MDR_DBUS;
                            dbus_valid_o <= 1'b1;
                        end
                    end
                end
                MDR_CLINT: begin
                    if (clint_ready_i) begin
                        state         <= MDR_RESP;
                        clint_valid_o <= 1'b0;
                        mdr_rsp_o     <= 1'b1;
                        mdr_err_o     <= (clint_resp_i != 2'b00);
                        mdr_rdata_o   <= (req_q == REQ_WRITE) ? '0 : load_aligned;
                    end
                end
                MDR_DBUS: begin
                    if (dbus_ready_i) begin
                        state        <= MDR_RESP;
                        dbus_valid_o <= 1'b0;
                        mdr_rsp_o    <= 1'b1;
                        mdr_err_o    <= (dbus_resp_i != 2'b00);
                        mdr_rdata_o  <= (req_q == REQ_WRITE) ? '0 : load_aligned;
                    end
                end
                default: begin
                    state       <= MDR_IDLE;
                    mdr_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dev_router.sv
// Scoreboard bench for mem_dev_router: directed requests push expected responses,
// a monitor pops and compares data, error flag and response cycle.
module tb_mem_dev_router;
    import mem_dev_router_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        mdr_valid_i = 1'b0;
    logic        mdr_req_i   = REQ_READ;
    logic [63:0] mdr_addr_i  = '0;
    logic [1:0]  mdr_size_i  = SIZE_B;
    logic [63:0] mdr_wdata_i = '0;
    logic        mdr_ready_o, mdr_rsp_o, mdr_err_o;
    logic [63:0] mdr_rdata_o;

    logic        clint_valid_o, clint_req_o;
    logic [63:0] clint_addr_o, clint_wdata_o;
    logic [1:0]  clint_size_o;
    logic        clint_ready_i = 1'b1;
    logic [63:0] clint_rdata_i = 64'h10;
    logic [1:0]  clint_resp_i  = 2'b00;

    logic        dbus_valid_o, dbus_req_o;
    logic [63:0] dbus_addr_o, dbus_wdata_o;
    logic [1:0]  dbus_size_o;
    logic        dbus_ready_i = 1'b0;
    logic [63:0] dbus_rdata_i = '0;
    logic [1:0]  dbus_resp_i  = 2'b00;

    mem_dev_router dut (
        .clk(clk), .rst(rst),
        .mdr_valid_i(mdr_valid_i), .mdr_req_i(mdr_req_i), .mdr_addr_i(mdr_addr_i),
        .mdr_size_i(mdr_size_i), .mdr_wdata_i(mdr_wdata_i), .mdr_ready_o(mdr_ready_o),
        .mdr_rsp_o(mdr_rsp_o), .mdr_rdata_o(mdr_rdata_o), .mdr_err_o(mdr_err_o),
        .clint_valid_o(clint_valid_o), .clint_req_o(clint_req_o), .clint_addr_o(clint_addr_o),
        .clint_size_o(clint_size_o), .clint_wdata_o(clint_wdata_o), .clint_ready_i(clint_ready_i),
        .clint_rdata_i(clint_rdata_i), .clint_resp_i(clint_resp_i),
        .dbus_valid_o(dbus_valid_o), .dbus_req_o(dbus_req_o), .dbus_addr_o(dbus_addr_o),
        .dbus_size_o(dbus_size_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ready_i(dbus_ready_i),
        .dbus_rdata_i(dbus_rdata_i), .dbus_resp_i(dbus_resp_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          at;
    } exp_t;
    exp_t sb[$];

    // Monitor: every response must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && mdr_rsp_o) begin
            exp_t e;
            check("rsp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_rdata", mdr_rdata_o, e.rdata);
                check("rsp_err", 64'(mdr_err_o), 64'(e.err));
                check("rsp_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    // Data-bus target: asserts ready after dbus_wait cycles of valid.
    int dbus_wait = 0;
    int wait_cnt  = 0;
    always @(negedge clk) begin
        if (dbus_valid_o && !dbus_ready_i) begin
            if (wait_cnt >= dbus_wait) dbus_ready_i = 1'b1;
            else wait_cnt++;
        end else begin
            dbus_ready_i = 1'b0;
            wait_cnt     = 0;
        end
    end

    int dbus_seen  = 0;
    int clint_seen = 0;
    always @(negedge clk) begin
        if (dbus_valid_o) dbus_seen++;
        if (clint_valid_o) clint_seen++;
    end

    task automatic push(input logic [63:0] rdata, input logic err, input int at);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.at    = at;
        sb.push_back(e);
    endtask

    // Presents a request and returns the posedge index at which it was accepted.
    task automatic issue(input logic req, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, output int acc);
        int n = 0;
        @(negedge clk);
        mdr_valid_i = 1'b1;
        mdr_req_i   = req;
        mdr_addr_i  = addr;
        mdr_size_i  = size;
        mdr_wdata_i = wdata;
        while (!mdr_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mdr_ready_o) begin
            check("accept_timeout", 64'(mdr_ready_o), 64'd1);
            mdr_valid_i = 1'b0;
            acc = -100;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int e, e1, e2;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(mdr_ready_o), 64'd1);
        check("reset_rsp", 64'(mdr_rsp_o), 64'd0);
        check("reset_err", 64'(mdr_err_o), 64'd0);
        check("reset_rdata", mdr_rdata_o, 64'd0);
        check("reset_clint_valid", 64'(clint_valid_o), 64'd0);
        check("reset_dbus_valid", 64'(dbus_valid_o), 64'd0);

        // CLINT doubleword store: one-cycle valid, data unshifted, response one cycle later.
        issue(REQ_WRITE, 64'h0200_4000, SIZE_D, 64'h1234, e);
        mdr_valid_i = 1'b0;
        push(64'h0, 1'b0, e + 1);
        @(negedge clk);
        check("t1_clint_valid", 64'(clint_valid_o), 64'd1);
        check("t1_clint_wdata", clint_wdata_o, 64'h1234);
        check("t1_clint_addr", clint_addr_o, 64'h0200_4000);
        check("t1_clint_req", 64'(clint_req_o), 64'(REQ_WRITE));
        check("t1_dbus_idle", 64'(dbus_valid_o), 64'd0);
        @(negedge clk);
        check("t1_clint_valid_drop", 64'(clint_valid_o), 64'd0);
        drain();

        // CLINT doubleword load of mtime; data bus must stay idle.
        dbus_seen = 0;
        issue(REQ_READ, 64'h0200_BFF8, SIZE_D, 64'h0, e);
        mdr_valid_i = 1'b0;
        push(64'h10, 1'b0, e + 1);
        drain();
        check("t2_no_dbus", 64'(dbus_seen), 64'd0);

        // Data-bus byte load with 3 stall cycles; fields held stable meanwhile.
        dbus_wait    = 3;
        dbus_rdata_i = 64'hAABBCCDD_11223344;
        issue(REQ_READ, 64'h8000_0003, SIZE_B, 64'h0, e);
        mdr_valid_i = 1'b0;
        push(64'h11, 1'b0, e + 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(dbus_valid_o), 64'd1);
            check("t3_hold_addr", dbus_addr_o, 64'h8000_0003);
            check("t3_hold_size", 64'(dbus_size_o), 64'(SIZE_B));
        end
        drain();

        // Data-bus halfword load from the top lanes.
        dbus_wait = 0;
        issue(REQ_READ, 64'h8000_0006, SIZE_H, 64'h0, e);
        mdr_valid_i = 1'b0;
        push(64'hAABB, 1'b0, e + 1);
        drain();

        // Data-bus word store: store data moves to the addressed lanes.
        dbus_wait = 1;
        issue(REQ_WRITE, 64'h8000_0004, SIZE_W, 64'hDEAD_BEEF, e);
        mdr_valid_i = 1'b0;
        push(64'h0, 1'b0, e + 2);
        @(negedge clk);
        check("t3b_dbus_wdata", dbus_wdata_o, 64'hDEADBEEF_00000000);
        check("t3b_dbus_req", 64'(dbus_req_o), 64'(REQ_WRITE));
        drain();

        // Misaligned halfword store: immediate error response, no target access.
        dbus_wait  = 0;
        dbus_seen  = 0;
        clint_seen = 0;
        issue(REQ_WRITE, 64'h8000_0001, SIZE_H, 64'h55, e);
        mdr_valid_i = 1'b0;
        push(64'h0, 1'b1, e);
        @(negedge clk);
        check("t4_ready_in_resp", 64'(mdr_ready_o), 64'd0);
        @(negedge clk);
        check("t4_ready_back", 64'(mdr_ready_o), 64'd1);
        check("t4_no_target", 64'(dbus_seen + clint_seen), 64'd0);
        drain();

        // Bus error on a word load, then a back-to-back CLINT request.
        dbus_resp_i  = 2'b10;
        dbus_rdata_i = 64'h0000_0001_CAFE_F00D;
        issue(REQ_READ, 64'h8000_0008, SIZE_W, 64'h0, e1);
        push(64'hCAFE_F00D, 1'b1, e1 + 1);
        issue(REQ_READ, 64'h0200_0008, SIZE_W, 64'h0, e2);
        mdr_valid_i = 1'b0;
        push(64'h10, 1'b0, e2 + 1);
        check("t5_b2b_accept", 64'(e2), 64'(e1 + 3));
        drain();
        dbus_resp_i = 2'b00;

        // Reset while the data bus stalls: request abandoned, no response.
        dbus_wait = 1000;
        issue(REQ_READ, 64'h8000_0020, SIZE_D, 64'h0, e);
        mdr_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_stalled", 64'(dbus_valid_o), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_dbus_valid_drop", 64'(dbus_valid_o), 64'd0);
        check("t6_ready", 64'(mdr_ready_o), 64'd1);
        check("t6_no_rsp", 64'(mdr_rsp_o), 64'd0);
        repeat (5) @(negedge clk);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);
        dbus_wait = 0;

        // Recovery after reset: CLINT byte load.
        issue(REQ_READ, 64'h0200_0000, SIZE_B, 64'h0, e);
        mdr_valid_i = 1'b0;
        push(64'h10, 1'b0, e + 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
